uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the UART link: it serialises one byte per frame onto `tx_o` as 8N1 (start bit, data bits LSB first, stop bit). It shares the 16x oversampling `tick` and the `clk_master` domain with `UART_RX`, so a `uart_tx` → `UART_RX` loopback works with no glue logic. Upstream logic, such as the CRC engine or the host interface, hands it bytes through a start/busy/done handshake.

## Interface
- `DATA_BITS`, default 8: data bits per frame.
- `OVERSAMPLE`, default 16: `tick` rising edges per bit period.
- `STOP_BITS`, default 1: stop bits per frame (1 or 2).

- `clk_master`  in  1  system clock; all state changes on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `tick`  in  1  oversampling reference; every detected rising edge counts as one tick.
- `tx_en`  in  1  transmitter enable; gates acceptance of new frames only.
- `tx_start_i`  in  1  request to send `data_i`; level-sampled.
- `data_i`  in  `DATA_BITS`  byte to send; captured only when a request is accepted.
- `tx_o`  out  1  serial line; idles high.
- `tx_busy`  out  1  high from acceptance until the frame completes.
- `tx_done`  out  1  one-cycle pulse at frame completion.

## Operation
- **Tick detection.** `tick_q` registers `tick` every cycle; `tick_rise = tick & ~tick_q`. `tick_q` resets to 1, so a `tick` already high at reset release is not counted.
- **States** (`tx_state_t`): IDLE, START, DATA, STOP.
- **IDLE.**
  - Drives `tx_o=1` and `tx_busy=0`.
  - If `tx_start_i & tx_en`: `shift_reg <= data_i`, `bit_cnt <= 0`, `os_cnt <= 0`, go to START.
  - Otherwise the request is ignored and is not remembered.
- **START.** `tx_o=0`. On the `tick_rise` with `os_cnt==OVERSAMPLE-1`: go to DATA and clear `os_cnt`.
- **DATA.**
  - `tx_o = shift_reg[0]`.
  - On each bit-end rise: shift `shift_reg` right by one and increment `bit_cnt`.
  - After bit `DATA_BITS-1` ends: go to STOP and clear `bit_cnt`.
- **STOP.**
  - `tx_o=1`.
  - After `STOP_BITS` bit periods: go to IDLE and pulse `tx_done` for one cycle, registered and coincident with the first IDLE cycle.
- **`os_cnt`.**
  - Width is `$clog2(OVERSAMPLE)`.
  - Increments only on `tick_rise` and wraps to 0 at each bit end.
  - Cycles without `tick_rise` hold all state.
- **`tx_busy`.** Equals `state != IDLE`.
- **`tx_en` low mid-frame.** The current frame completes unchanged; only new requests are blocked.
- **`tx_start_i` while busy.** Ignored; `data_i` changes have no effect on the frame in flight.
- **Back-to-back frames.** `tx_start_i` high in the cycle `tx_done` pulses is accepted. The next start bit then follows the stop bit with no extra idle time.
- **Reset, including mid-frame.** Immediately forces:
  - `state=IDLE`, `tx_o=1`, `tx_busy=0`, `tx_done=0`
  - `shift_reg=0`, `os_cnt=0`, `bit_cnt=0`, `tick_q=1`
  - The partial frame is abandoned.

## Timing
- `tx_o` is a registered output with no combinational path from any input.
- Acceptance to `tx_o` falling: 1 `clk_master` cycle.
- Each bit lasts exactly `OVERSAMPLE` tick rises. Transitions happen on the `clk_master` edge that registers the terminating rise, so bit boundaries carry a fixed 1-cycle latency after `tick` rises.
- Frame length is `(1+DATA_BITS+STOP_BITS)*OVERSAMPLE` tick rises: 160 at defaults.
- `tx_done` is high for exactly 1 cycle per frame and never asserts after reset alone.

## Structure
- `uart_pkg` holds `tx_state_t`, `UART_OVERSAMPLE=16` and `UART_DATA_BITS=8`. These are shared with `UART_RX` so both ends agree on frame format.
- One natural sub-module, `uart_tick_edge`: the `tick` rising-edge detector. It is reusable by `UART_RX`.
- The rest (FSM, counters, shift register) stays flat in `uart_tx`: about 150 lines.

## Test plan
- **Byte 0xA5, `tx_en=1`, tick from the divide-by-8 generator:**
  - `tx_o` sequence per 16 tick rises: 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_busy` is high for exactly 160 rises.
  - `tx_done` pulses once.
- **Loopback into `UART_RX`** with 0x4D, 0xE2, 0xAB, 0x8A sent back-to-back (start held high):
  - `rx_done` fires 4 times and `data_o` matches in order.
  - No idle gap between stop and the next start.
- **`tx_start_i` pulsed mid-frame with a different `data_i`:** ignored; the transmitted byte is unchanged and there is exactly one `tx_done`.
- **`tx_en=0` with `tx_start_i=1`:** `tx_o` stays 1 and `tx_busy` stays 0. Dropping `tx_en` during DATA still completes the frame.
- **`rst_i` asserted during bit 3 of 0x00:**
  - `tx_o=1` and `tx_busy=0` immediately, with no `tx_done`.
  - After release, a new 0x3C transmits correctly.
- **`tick` held high across reset release:** no spurious count; the first bit still spans exactly 16 rises.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART frame-format definitions. The transmitter and
//                the receiver both import this package so the two ends of
//                a link always agree on oversampling and character size.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Default oversampling ratio: tick rising edges per bit period
   localparam int UART_OVERSAMPLE = 16;

   // Default number of data bits per character
   localparam int UART_DATA_BITS  = 8;

   // Transmitter frame phases
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tick_edge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tick_edge
//  Description : Rising-edge detector for the shared oversampling tick.
//                The history flop resets high so a tick that is already
//                high when reset is released does not count as a rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tick_edge (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   output logic tick_rise
);

   logic tick_q;

   // Remember the previous tick level; reset high to suppress a false rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q <= 1'b1;
      end else begin
         tick_q <= tick;
      end
   end

   assign tick_rise = tick & ~tick_q;

endmodule : uart_tick_edge
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1-style serial transmitter driven by the shared 16x
//                oversampling tick. Accepts one character per start/busy/
//                done handshake and shifts it out LSB first between a start
//                bit and STOP_BITS stop bits. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk_master,
   input  logic                 rst_i,
   input  logic                 tick,
   input  logic                 tx_en,
   input  logic                 tx_start_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic                 tx_o,
   output logic                 tx_busy,
   output logic                 tx_done
);

   // Oversample counter width; kept at least one bit wide for degenerate ratios
   localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   // Bit counter must hold both the data index and the stop-bit index
   localparam int BC_W = $clog2(DATA_BITS + STOP_BITS + 1);

   localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
   localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

   tx_state_t            state;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_next;
   logic [OS_W-1:0]      os_cnt;
   logic [BC_W-1:0]      bit_cnt;
   logic                 tick_rise;
   logic                 bit_end;

   uart_tick_edge u_tick_edge (
      .clk       (clk_master),
      .rst       (rst_i),
      .tick      (tick),
      .tick_rise (tick_rise)
   );

   // A bit period ends on the tick rise that completes OVERSAMPLE rises
   assign bit_end    = tick_rise && (os_cnt == OS_LAST);

   // Shift register contents after the current data bit has been sent
   assign shift_next = shift_reg >> 1;

   // Frame sequencer: state, counters, shifter and registered line outputs
   always_ff @(posedge clk_master or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         shift_reg <= '0;
         os_cnt    <= '0;
         bit_cnt   <= '0;
         tx_o      <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               tx_o    <= 1'b1;
               tx_busy <= 1'b0;
               // Requests are level-sampled and never queued while disabled
               if (tx_start_i && tx_en) begin
                  shift_reg <= data_i;
                  bit_cnt   <= '0;
                  os_cnt    <= '0;
                  state     <= START;
                  tx_o      <= 1'b0;
                  tx_busy   <= 1'b1;
               end
            end

            START: begin
               if (tick_rise) begin
                  if (bit_end) begin
                     os_cnt <= '0;
                     state  <= DATA;
                     tx_o   <= shift_reg[0];
                  end else begin
                     os_cnt <= os_cnt + OS_W'(1);
                  end
               end
            end

            DATA: begin
               if (tick_rise) begin
                  if (bit_end) begin
                     os_cnt    <= '0;
                     shift_reg <= shift_next;
                     if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                        tx_o    <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                        tx_o    <= shift_next[0];
                     end
                  end else begin
                     os_cnt <= os_cnt + OS_W'(1);
                  end
               end
            end

            STOP: begin
               if (tick_rise) begin
                  if (bit_end) begin
                     os_cnt <= '0;
                     if (bit_cnt == STOP_LAST) begin
                        // Done pulse lands on the first IDLE cycle so a
                        // held request starts the next frame immediately
                        bit_cnt <= '0;
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        tx_o    <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                     end
                  end else begin
                     os_cnt <= os_cnt + OS_W'(1);
                  end
               end
            end

            default: begin
               state   <= IDLE;
               tx_o    <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. A frame-position model
//                predicts the line, busy and done outputs each cycle, and a
//                bench-side receiver decodes the serial line into bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

   localparam int OS    = 16;
   localparam int DB    = 8;
   localparam int SB    = 1;
   localparam int FRAME = (1 + DB + SB) * OS;

   logic       clk_master = 1'b0;
   logic       rst_i;
   logic       tick;
   logic       tx_en;
   logic       tx_start_i;
   logic [7:0] data_i;
   logic       tx_o;
   logic       tx_busy;
   logic       tx_done;

   uart_tx #(
      .DATA_BITS  (DB),
      .OVERSAMPLE (OS),
      .STOP_BITS  (SB)
   ) dut (
      .clk_master (clk_master),
      .rst_i      (rst_i),
      .tick       (tick),
      .tx_en      (tx_en),
      .tx_start_i (tx_start_i),
      .data_i     (data_i),
      .tx_o       (tx_o),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clk_master = ~clk_master;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- behavioural model: position within frame ----------
   logic       m_busy, m_txo, m_done, m_tq, m_rise;
   int         m_pos;
   logic [7:0] m_data;
   logic [7:0] exp_q[$];

   function automatic logic bitval(input int pos, input logic [7:0] d);
      int b;
      b = pos / OS;
      if (b == 0)       return 1'b0;
      else if (b <= DB) return d[b-1];
      else              return 1'b1;
   endfunction

   always @(posedge clk_master or posedge rst_i) begin
      if (rst_i) begin
         m_busy = 1'b0; m_txo = 1'b1; m_done = 1'b0; m_tq = 1'b1; m_pos = 0;
         exp_q.delete();
      end else begin
         m_rise = tick & ~m_tq;
         m_tq   = tick;
         m_done = 1'b0;
         if (!m_busy) begin
            if (tx_start_i && tx_en) begin
               m_busy = 1'b1; m_pos = 0; m_data = data_i;
               exp_q.push_back(data_i);
            end
         end else if (m_rise) begin
            m_pos++;
            if (m_pos == FRAME) begin
               m_busy = 1'b0; m_done = 1'b1;
            end
         end
         m_txo = m_busy ? bitval(m_pos, m_data) : 1'b1;
      end
   end

   // ---------------- per-cycle compare and line monitor ----------------
   logic       mon_tq, rise_now, active;
   int         rcnt;
   logic       rbits[10];
   logic       last_bits[10];
   logic [7:0] rbyte;
   logic [7:0] rx_q[$];
   int         done_cnt = 0, busy_rises = 0, low_rises = 0, idle_cycles = 0;

   always @(negedge clk_master) begin
      chk("tx_o",    tx_o,    m_txo);
      chk("tx_busy", tx_busy, m_busy);
      chk("tx_done", tx_done, m_done);
      if (rst_i) begin
         mon_tq = 1'b1; active = 1'b0; rcnt = 0;
      end else begin
         rise_now = tick & ~mon_tq;
         mon_tq   = tick;
         if (tx_done)                        done_cnt++;
         if (!tx_busy)                       idle_cycles++;
         if (tx_busy && rise_now)            busy_rises++;
         if (tx_busy && !tx_o && rise_now)   low_rises++;
         if (!active && tx_busy && !tx_o) begin
            active = 1'b1; rcnt = 0;
         end
         if (active && rise_now) begin
            rcnt++;
            if (rcnt % OS == OS / 2) begin
               rbits[rcnt / OS] = tx_o;
               if (rcnt / OS == DB + 1) begin
                  for (int i = 0; i < DB; i++) rbyte[i] = rbits[i+1];
                  for (int i = 0; i < 10; i++) last_bits[i] = rbits[i];
                  chk("start_bit", rbits[0], 0);
                  chk("stop_bit", tx_o, 1);
                  rx_q.push_back(rbyte);
                  if (exp_q.size() > 0) chk("rx_byte", rbyte, exp_q.pop_front());
                  else                  chk("rx_unexpected_frame", 1, 0);
                  active = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- tick generator ----------------
   int   tick_mode = 0;
   logic tick_level = 1'b0;
   int   ph = 0;

   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk_master);
         #2;
         case (tick_mode)
            1:       begin tick = (ph < 4); ph = (ph + 1) % 8; end
            2:       tick = ($urandom_range(0, 2) == 0);
            default: tick = tick_level;
         endcase
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_master);
      #2;
   endtask

   task automatic wait_busy(input int limit);
      int t = 0;
      while (!tx_busy && t < limit) begin step(); t++; end
      chk("accept_timeout", tx_busy, 1);
   endtask

   task automatic send(input logic [7:0] d);
      data_i     = d;
      tx_start_i = 1'b1;
      step();
      wait_busy(20);
      tx_start_i = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int t = 0;
      while (tx_busy && t < limit) begin step(); t++; end
      chk("frame_timeout", tx_busy, 0);
   endtask

   task automatic wait_done(input int limit);
      int t = 0;
      while (!tx_done && t < limit) begin step(); t++; end
      chk("done_timeout", tx_done, 1);
   endtask

   logic exp_seq[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0] bytes4[4] = '{8'h4D, 8'hE2, 8'hAB, 8'h8A};
   int d0, b0, q0, i0, l0;

   initial begin
      rst_i = 1'b1; tx_en = 1'b0; tx_start_i = 1'b0; data_i = 8'h00;
      repeat (3) step();
      chk("reset_tx_o", tx_o, 1);
      chk("reset_tx_busy", tx_busy, 0);
      chk("reset_tx_done", tx_done, 0);
      rst_i = 1'b0;
      step();

      // 0xA5 with divide-by-8 tick
      tick_mode = 1; tx_en = 1'b1;
      d0 = done_cnt; b0 = busy_rises; q0 = rx_q.size();
      send(8'hA5);
      wait_idle(3000);
      step();
      chk("a5_done_count", done_cnt - d0, 1);
      chk("a5_busy_rises", busy_rises - b0, 160);
      chk("a5_rx_count", rx_q.size() - q0, 1);
      if (rx_q.size() > q0) chk("a5_rx_byte", rx_q[q0], 8'hA5);
      for (int i = 0; i < 10; i++) chk("a5_bit_seq", last_bits[i], exp_seq[i]);

      // back-to-back frames with the request held high
      d0 = done_cnt; q0 = rx_q.size();
      data_i = bytes4[0]; tx_start_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_busy(20);
         if (k == 0) i0 = idle_cycles;
         if (k == 3) begin
            tx_start_i = 1'b0;
            chk("b2b_idle_gaps", idle_cycles - i0, 3);
         end else begin
            data_i = bytes4[k+1];
            wait_done(3000);
         end
      end
      wait_idle(3000);
      step();
      chk("b2b_done_count", done_cnt - d0, 4);
      chk("b2b_rx_count", rx_q.size() - q0, 4);
      for (int k = 0; k < 4; k++)
         if (rx_q.size() > q0 + k) chk("b2b_rx_byte", rx_q[q0+k], bytes4[k]);

      // request pulsed mid-frame with different data
      d0 = done_cnt; q0 = rx_q.size();
      send(8'h5A);
      repeat (300) step();
      data_i = 8'hC3; tx_start_i = 1'b1;
      repeat (3) step();
      tx_start_i = 1'b0;
      wait_idle(3000);
      repeat (4) step();
      chk("midreq_done_count", done_cnt - d0, 1);
      if (rx_q.size() > q0) chk("midreq_rx_byte", rx_q[q0], 8'h5A);
      chk("midreq_rx_count", rx_q.size() - q0, 1);

      // disabled transmitter ignores requests; disabling mid-frame finishes
      tx_en = 1'b0; data_i = 8'h77; tx_start_i = 1'b1;
      repeat (50) step();
      chk("dis_tx_o", tx_o, 1);
      chk("dis_tx_busy", tx_busy, 0);
      tx_start_i = 1'b0; tx_en = 1'b1;
      step();
      d0 = done_cnt; q0 = rx_q.size();
      send(8'h96);
      repeat (400) step();
      tx_en = 1'b0;
      wait_idle(3000);
      tx_en = 1'b1;
      step();
      chk("endrop_done_count", done_cnt - d0, 1);
      if (rx_q.size() > q0) chk("endrop_rx_byte", rx_q[q0], 8'h96);

      // reset during bit 3 of 0x00
      d0 = done_cnt;
      send(8'h00);
      begin
         int t = 0;
         while (m_pos < 4 * OS + 5 && t < 2000) begin step(); t++; end
         chk("reach_bit3", m_pos >= 4 * OS + 5, 1);
      end
      rst_i = 1'b1;
      #1;
      chk("midrst_tx_o", tx_o, 1);
      chk("midrst_tx_busy", tx_busy, 0);
      chk("midrst_tx_done", tx_done, 0);
      repeat (3) step();
      rst_i = 1'b0;
      repeat (3) step();
      chk("midrst_no_done", done_cnt - d0, 0);
      d0 = done_cnt; q0 = rx_q.size();
      send(8'h3C);
      wait_idle(3000);
      step();
      chk("postrst_done_count", done_cnt - d0, 1);
      chk("postrst_rx_count", rx_q.size() - q0, 1);
      if (rx_q.size() > q0) chk("postrst_rx_byte", rx_q[q0], 8'h3C);

      // tick held high across reset release
      tick_mode = 0; tick_level = 1'b1;
      step(); step();
      rst_i = 1'b1;
      repeat (3) step();
      rst_i = 1'b0;
      repeat (3) step();
      l0 = low_rises; q0 = rx_q.size();
      send(8'hFF);
      ph = 0; tick_mode = 1;
      wait_idle(3000);
      step();
      chk("tickhigh_start_rises", low_rises - l0, 16);
      if (rx_q.size() > q0) chk("tickhigh_rx_byte", rx_q[q0], 8'hFF);

      // randomized frames with noise on start, data and enable mid-frame
      tick_mode = 2;
      q0 = rx_q.size(); d0 = done_cnt;
      for (int n = 0; n < 6; n++) begin
         send(8'($urandom));
         for (int c = 0; c < 100; c++) begin
            step();
            tx_start_i = 1'($urandom);
            data_i     = 8'($urandom);
            tx_en      = 1'($urandom);
         end
         tx_start_i = 1'b0; tx_en = 1'b1;
         wait_idle(5000);
         step();
      end
      chk("rand_rx_count", rx_q.size() - q0, 6);
      chk("rand_done_count", done_cnt - d0, 6);

      repeat (4) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_tx
`default_nettype wire
